// File: rtl/ff_mode_reg.sv
// WIDTH-bit mode register: hold, parallel load, shift and count, with synchronous reset/preset.
// Define FF_MODE_REG_SATURATE_EN to make count mode saturate at the limits instead of wrapping.
module ff_mode_reg #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0,
   parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             preset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             dir,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             tc
);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_LOAD  = 2'b01;
   localparam logic [1:0] MODE_SHIFT = 2'b10;
   localparam logic [1:0] MODE_COUNT = 2'b11;

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ZERO     = '0;
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   // Limit the count is heading toward in the current direction.
   logic [WIDTH-1:0] count_limit;
   logic [WIDTH-1:0] count_next;

   always_comb begin
      count_limit = dir ? ZERO : ALL_ONES;
      count_next  = dir ? (q - ONE) : (q + ONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q    <= RESET_VAL;
         sout <= 1'b0;
         tc   <= 1'b0;
      end else if (preset) begin
         q    <= PRESET_VAL;
         sout <= 1'b0;
         tc   <= 1'b0;
      end else if (en) begin
         case (mode)
            MODE_HOLD: begin
            end
            MODE_LOAD: begin
               q  <= d;
               tc <= 1'b0;
            end
            MODE_SHIFT: begin
               if (dir) begin
                  q    <= {sin, q[WIDTH-1:1]};
                  sout <= q[0];
               end else begin
                  q    <= {q[WIDTH-2:0], sin};
                  sout <= q[WIDTH-1];
               end
               tc <= 1'b0;
            end
            MODE_COUNT: begin
`ifdef FF_MODE_REG_SATURATE_EN
               // Pinned at the limit: q stays put and tc stays high every count edge.
               if (q == count_limit) begin
                  tc <= 1'b1;
               end else begin
                  q  <= count_next;
                  tc <= 1'b0;
               end
`else
               q  <= count_next;
               tc <= (q == count_limit);
`endif
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ff_mode_reg.sv
// Directed bench for ff_mode_reg (WIDTH=8, RESET_VAL=8'h5A) with hand-computed expectations.
module tb_ff_mode_reg;

   logic       clk;
   logic       rst;
   logic       preset;
   logic       en;
   logic [1:0] mode;
   logic       dir;
   logic [7:0] d;
   logic       sin;
   logic [7:0] q;
   logic       sout;
   logic       tc;

   int n_checks = 0;
   int n_fail   = 0;

   ff_mode_reg #(
      .WIDTH(8),
      .RESET_VAL(8'h5A),
      .PRESET_VAL(8'hFF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .preset(preset),
      .en(en),
      .mode(mode),
      .dir(dir),
      .d(d),
      .sin(sin),
      .q(q),
      .sout(sout),
      .tc(tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_all(input string tag, input logic [7:0] eq, input logic es, input logic et);
      check({tag, ".q"}, 64'(q), 64'(eq));
      check({tag, ".sout"}, 64'(sout), 64'(es));
      check({tag, ".tc"}, 64'(tc), 64'(et));
   endtask

   initial begin
      rst = 1'b0; preset = 1'b0; en = 1'b0; mode = 2'b00; dir = 1'b0; d = 8'h00; sin = 1'b0;
      #2;

      // rst beats preset and load
      rst = 1'b1; preset = 1'b1; en = 1'b1; mode = 2'b01; d = 8'hFF;
      tick();
      expect_all("reset", 8'h5A, 1'b0, 1'b0);

      rst = 1'b0; preset = 1'b0; mode = 2'b01; d = 8'h10;
      tick();
      expect_all("load10", 8'h10, 1'b0, 1'b0);

      // preset beats count
      preset = 1'b1; mode = 2'b11;
      tick();
      expect_all("preset", 8'hFF, 1'b0, 1'b0);

      preset = 1'b0; en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("en0_hold.q", 64'(q), 64'h00FF);
      end

      en = 1'b1; mode = 2'b01; d = 8'hA5;
      tick();
      expect_all("loadA5", 8'hA5, 1'b0, 1'b0);

      mode = 2'b10; dir = 1'b0; sin = 1'b1;
      tick();
      expect_all("shl1", 8'h4B, 1'b1, 1'b0);

      sin = 1'b0;
      tick();
      expect_all("shl2", 8'h96, 1'b0, 1'b0);

      dir = 1'b1; sin = 1'b1;
      tick();
      expect_all("shr1", 8'hCB, 1'b0, 1'b0);

      sin = 1'b0;
      tick();
      expect_all("shr2", 8'h65, 1'b1, 1'b0);

      // hold mode ignores dir and keeps sout
      mode = 2'b00; dir = 1'b0;
      tick();
      expect_all("mode_hold", 8'h65, 1'b1, 1'b0);

      mode = 2'b01; d = 8'hFE; dir = 1'b1;
      tick();
      expect_all("loadFE", 8'hFE, 1'b1, 1'b0);

      mode = 2'b11; dir = 1'b0;
`ifdef FF_MODE_REG_SATURATE_EN
      tick(); expect_all("up1", 8'hFF, 1'b1, 1'b0);
      tick(); expect_all("up2", 8'hFF, 1'b1, 1'b1);
      tick(); expect_all("up3", 8'hFF, 1'b1, 1'b1);
`else
      tick(); expect_all("up1", 8'hFF, 1'b1, 1'b0);
      tick(); expect_all("up2", 8'h00, 1'b1, 1'b1);
      tick(); expect_all("up3", 8'h01, 1'b1, 1'b0);
`endif

      mode = 2'b01; d = 8'h01;
      tick();
      expect_all("load01", 8'h01, 1'b1, 1'b0);

      mode = 2'b11; dir = 1'b1;
`ifdef FF_MODE_REG_SATURATE_EN
      tick(); expect_all("dn1", 8'h00, 1'b1, 1'b0);
      tick(); expect_all("dn2", 8'h00, 1'b1, 1'b1);
      tick(); expect_all("dn3", 8'h00, 1'b1, 1'b1);
      en = 1'b0;
      tick(); expect_all("tc_en0", 8'h00, 1'b1, 1'b1);
      en = 1'b1; mode = 2'b00;
      tick(); expect_all("tc_mode0", 8'h00, 1'b1, 1'b1);
`else
      tick(); expect_all("dn1", 8'h00, 1'b1, 1'b0);
      tick(); expect_all("dn2", 8'hFF, 1'b1, 1'b1);
      en = 1'b0;
      tick(); expect_all("tc_en0", 8'hFF, 1'b1, 1'b1);
      en = 1'b1; mode = 2'b00;
      tick(); expect_all("tc_mode0", 8'hFF, 1'b1, 1'b1);
`endif

      // mid-count reset
      mode = 2'b01; d = 8'h20;
      tick();
      expect_all("load20", 8'h20, 1'b1, 1'b0);
      mode = 2'b11; dir = 1'b0;
      tick(); check("cnt21.q", 64'(q), 64'h21);
      tick(); check("cnt22.q", 64'(q), 64'h22);
      rst = 1'b1;
      tick();
      expect_all("mid_rst", 8'h5A, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      expect_all("resume", 8'h5B, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
